// File: rtl/fifo_reg_buf.sv
// Register-array FIFO with registered read data and count-decoded flags.
// Accepts a write into a full FIFO when a read frees an entry on the same edge.
module fifo_reg_buf #(
  parameter int DATA_WIDTH       = 8,
  parameter int DATA_DEPTH       = 16,
  parameter int ALMOST_FULL_VAL  = DATA_DEPTH - 2,
  parameter int ALMOST_EMPTY_VAL = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_dv,
  input  logic [DATA_WIDTH-1:0] wr_DATA,
  output logic                  wr_full,
  output logic                  wr_almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_DATA,
  output logic                  rd_empty,
  output logic                  rd_almost_empty
);

  localparam int CNT_W = $clog2(DATA_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DATA_DEPTH);
  localparam logic [CNT_W-1:0] LAST_IDX_C = CNT_W'(DATA_DEPTH - 1);
  localparam logic [CNT_W-1:0] AFULL_C    = CNT_W'(ALMOST_FULL_VAL);
  localparam logic [CNT_W-1:0] AEMPTY_C   = CNT_W'(ALMOST_EMPTY_VAL);

  logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DATA_DEPTH];
  logic [CNT_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  rd_accept;
  logic                  wr_accept;

  assign rd_empty        = (count_q == '0);
  assign rd_almost_empty = (count_q <= AEMPTY_C);
  assign wr_full         = (count_q == DEPTH_C);
  assign wr_almost_full  = (count_q >= AFULL_C);
  assign rd_DATA         = rd_data_q;

  always_comb begin
    rd_accept = rd_en && !rd_empty;
    wr_accept = wr_dv && (!wr_full || rd_accept);
  end

  // Read mux looks only at stored entries, so same-edge write data never bypasses.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < DATA_DEPTH; i++) begin
      if (rd_ptr_q == CNT_W'(i)) begin
        rd_word = mem_q[i];
      end
    end
  end

  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < DATA_DEPTH; i++) begin
      if (wr_accept && (wr_ptr_q == CNT_W'(i))) begin
        mem_d[i] = wr_DATA;
      end
    end
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;

    // Explicit wrap keeps non-power-of-two depths correct.
    if (wr_accept) begin
      wr_ptr_d = (wr_ptr_q == LAST_IDX_C) ? '0 : wr_ptr_q + CNT_W'(1);
    end
    if (rd_accept) begin
      rd_ptr_d  = (rd_ptr_q == LAST_IDX_C) ? '0 : rd_ptr_q + CNT_W'(1);
      rd_data_d = rd_word;
    end

    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_fifo_reg_buf.sv
// Self-checking bench for fifo_reg_buf: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_fifo_reg_buf;

  localparam int DW    = 4;
  localparam int DEPTH = 8;
  localparam int AFV   = 6;
  localparam int AEV   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_dv = 1'b0;
  logic [DW-1:0] wr_DATA = '0;
  logic          wr_full;
  logic          wr_almost_full;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_DATA;
  logic          rd_empty;
  logic          rd_almost_empty;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_rd = '0;

  fifo_reg_buf #(
    .DATA_WIDTH      (DW),
    .DATA_DEPTH      (DEPTH),
    .ALMOST_FULL_VAL (AFV),
    .ALMOST_EMPTY_VAL(AEV)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_dv          (wr_dv),
    .wr_DATA        (wr_DATA),
    .wr_full        (wr_full),
    .wr_almost_full (wr_almost_full),
    .rd_en          (rd_en),
    .rd_DATA        (rd_DATA),
    .rd_empty       (rd_empty),
    .rd_almost_empty(rd_almost_empty)
  );

  always #5 clk = ~clk;

  // Drive one edge, advance the reference model, then sample 1 ns after the edge.
  task automatic drive(input logic r, input logic w, input logic [DW-1:0] d, input logic re);
    bit ra;
    bit wa;
    rst = r; wr_dv = w; wr_DATA = d; rd_en = re;
    @(posedge clk);
    if (!r) begin
      model_q.delete();
      exp_rd = '0;
    end else begin
      ra = re && (model_q.size() > 0);
      wa = w && ((model_q.size() < DEPTH) || ra);
      if (ra) exp_rd = model_q.pop_front();
      if (wa) model_q.push_back(d);
    end
    #1;
    $display("txn t=%0t rst=%b wr=%b d=%h rd=%b -> rd_DATA=%h flags(e,ae,af,f)=%b%b%b%b model_cnt=%0d",
             $time, r, w, d, re, rd_DATA, rd_empty, rd_almost_empty, wr_almost_full, wr_full,
             model_q.size());
    rst = 1'b1; wr_dv = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0);
    checks++;
    if ({rd_empty, rd_almost_empty, wr_almost_full, wr_full} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_flags: got %b want 1100",
               {rd_empty, rd_almost_empty, wr_almost_full, wr_full});
    end
    checks++;
    if (rd_DATA !== 4'h0) begin
      errors++;
      $display("FAIL reset_rd_data: got %h want 0", rd_DATA);
    end
  endtask

  task automatic test_fill();
    logic [3:0] exp_flags;
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 1'b1, 4'(7 + k), 1'b0);
      exp_flags = {1'b0, (k < 3), (k >= 6), (k >= 8)};
      checks++;
      if ({rd_empty, rd_almost_empty, wr_almost_full, wr_full} !== exp_flags) begin
        errors++;
        $display("FAIL fill_flags_w%0d: got %b want %b", k,
                 {rd_empty, rd_almost_empty, wr_almost_full, wr_full}, exp_flags);
      end
    end
  endtask

  task automatic test_overflow();
    drive(1'b1, 1'b1, 4'h8, 1'b0);
    checks++;
    if ({rd_empty, wr_almost_full, wr_full} !== 3'b011) begin
      errors++;
      $display("FAIL overflow_flags: got %b want 011", {rd_empty, wr_almost_full, wr_full});
    end
  endtask

  task automatic test_drain();
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b0, '0, 1'b1);
      checks++;
      if (rd_DATA !== 4'(8 + k)) begin
        errors++;
        $display("FAIL drain_data_%0d: got %h want %h", k, rd_DATA, 4'(8 + k));
      end
    end
    checks++;
    if (rd_empty !== 1'b1) begin
      errors++;
      $display("FAIL drain_empty: got %b want 1", rd_empty);
    end
    drive(1'b1, 1'b0, '0, 1'b1);
    checks++;
    if (rd_DATA !== 4'hF) begin
      errors++;
      $display("FAIL drain_hold: got %h want f", rd_DATA);
    end
  endtask

  task automatic test_empty_read_write();
    drive(1'b1, 1'b1, 4'h8, 1'b1);
    checks++;
    if ({rd_DATA, rd_empty, rd_almost_empty, wr_full} !== {4'hF, 3'b010}) begin
      errors++;
      $display("FAIL empty_rw: got data=%h e=%b ae=%b f=%b want data=f e=0 ae=1 f=0",
               rd_DATA, rd_empty, rd_almost_empty, wr_full);
    end
    drive(1'b1, 1'b0, '0, 1'b1);
    checks++;
    if ({rd_DATA, rd_empty} !== {4'h8, 1'b1}) begin
      errors++;
      $display("FAIL empty_rw_next: got data=%h e=%b want data=8 e=1", rd_DATA, rd_empty);
    end
  endtask

  task automatic test_full_simultaneous();
    logic [DW-1:0] vals[DEPTH];
    logic [DW-1:0] extra;
    for (int k = 0; k < DEPTH; k++) begin
      vals[k] = 4'($urandom);
      drive(1'b1, 1'b1, vals[k], 1'b0);
    end
    extra = 4'($urandom);
    drive(1'b1, 1'b1, extra, 1'b1);
    checks++;
    if ({rd_DATA, wr_full} !== {vals[0], 1'b1}) begin
      errors++;
      $display("FAIL full_simul: got data=%h f=%b want data=%h f=1", rd_DATA, wr_full, vals[0]);
    end
    for (int k = 1; k <= DEPTH; k++) begin
      drive(1'b1, 1'b0, '0, 1'b1);
      checks++;
      if (rd_DATA !== ((k < DEPTH) ? vals[k] : extra)) begin
        errors++;
        $display("FAIL full_simul_order_%0d: got %h want %h", k, rd_DATA,
                 (k < DEPTH) ? vals[k] : extra);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 5; k++) drive(1'b1, 1'b1, 4'($urandom), 1'b0);
    drive(1'b1, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b1, 4'h3, 1'b1);
    checks++;
    if ({rd_DATA, rd_empty, rd_almost_empty, wr_almost_full, wr_full} !== {4'h0, 4'b1100}) begin
      errors++;
      $display("FAIL reset_mid: got data=%h flags=%b want data=0 flags=1100", rd_DATA,
               {rd_empty, rd_almost_empty, wr_almost_full, wr_full});
    end
    drive(1'b1, 1'b0, '0, 1'b1);
    checks++;
    if ({rd_DATA, rd_empty} !== {4'h0, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid_read: got data=%h e=%b want data=0 e=1", rd_DATA, rd_empty);
    end
  endtask

  task automatic test_random();
    logic          r;
    logic          w;
    logic          re;
    int            sz;
    logic [DW+3:0] exp_v;
    for (int n = 0; n < 400; n++) begin
      // Alternate fill-biased and drain-biased phases to reach both boundaries.
      r  = ($urandom_range(0, 59) != 0);
      w  = ((n / 50) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      re = ((n / 50) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      drive(r, w, 4'($urandom), re);
      sz    = model_q.size();
      exp_v = {exp_rd, (sz == 0), (sz <= AEV), (sz >= AFV), (sz == DEPTH)};
      checks++;
      if ({rd_DATA, rd_empty, rd_almost_empty, wr_almost_full, wr_full} !== exp_v) begin
        errors++;
        $display("FAIL random_%0d: got data=%h flags=%b want data=%h flags=%b", n, rd_DATA,
                 {rd_empty, rd_almost_empty, wr_almost_full, wr_full}, exp_v[7:4], exp_v[3:0]);
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_empty_read_write();
    test_full_simultaneous();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
